sipo_deser: RTL and testbench
=============================

Name: sipo_deser

Overview:
Serial-in, parallel-out deserializer: the receive end of the team's 4-bit PISO serial link. Shifts in one bit per qualified clock and assembles WIDTH-bit words. Presents each completed word on a one-entry holding register with a valid/ready handshake toward the consumer. Sits between the serial link pin or line and the parallel datapath.

Parameters:
WIDTH, 4, word width in bits (≥2).
MSB_FIRST, 1, 1: first received bit lands in parallel_out[WIDTH-1]; 0: first bit lands in parallel_out[0].

Ports:
clk  input  1  system clock, all logic on posedge.
rst  input  1  synchronous, active-high reset.
serial_in  input  1  serial data bit.
serial_valid  input  1  serial_in is sampled on this clock edge when high.
sync  input  1  frame realign: discard any partial word, restart bit count.
parallel_out  output  WIDTH  holding-register word.
out_valid  output  1  parallel_out holds an unconsumed word.
out_ready  input  1  consumer accepts the word when out_valid && out_ready.
overrun  output  1  one-cycle pulse: a completed word was dropped.
bit_count  output  $clog2(WIDTH)  bits collected in the current partial word.

Behaviour:
- Reset (rst=1 at posedge): shift reg=0, bit_count=0, parallel_out=0, out_valid=0, overrun=0. Reset has priority over all inputs. Reset mid-word discards the partial word and any held word.
- Shift: on a posedge with serial_valid=1 and sync=0:
  - MSB_FIRST=1: shift left, serial_in enters bit 0.
  - MSB_FIRST=0: shift right, serial_in enters bit WIDTH-1.
  - bit_count increments.
- Completion: the edge that samples bit number WIDTH-1 (bit_count==WIDTH-1 && serial_valid) is the completion edge.
  - The assembled word (including this bit) is the candidate word.
  - bit_count wraps to 0.
  - Receiving continues with no gap; back-to-back words at one bit per clock are supported.
- Holding-register load on the completion edge:
  - If out_valid=0, or out_valid=1 with out_ready=1 in the same cycle: load parallel_out with the candidate word. out_valid is 1 from the next cycle. Latency is 1 cycle from the last bit's sampling edge.
  - If out_valid=1 and out_ready=0: drop the candidate word. parallel_out is unchanged. overrun=1 for exactly one cycle.
- Handshake:
  - Transfer happens when out_valid && out_ready at posedge; out_valid clears unless a new load occurs on the same edge.
  - parallel_out is stable while out_valid=1 && out_ready=0.
  - out_ready while out_valid=0 has no effect.
- sync=1 at posedge:
  - Clears bit_count and the shift register; serial_in is ignored that cycle.
  - Does not affect the holding register or out_valid.
  - sync wins over serial_valid.
- serial_valid=0: shift register and bit_count hold.
- Control state machine (derived from bit_count/out_valid; an explicit enum is not required):
  - EMPTY (out_valid=0) → FULL on a completion edge.
  - FULL → EMPTY on a transfer with no completion edge.
  - FULL → FULL on a transfer with a completion edge (reload).
  - FULL → FULL with an overrun pulse on a completion edge without a transfer.

Decomposition:
- Shared package serial_link_pkg: LINK_WIDTH=4 default, MSB_FIRST default, shared with the PISO transmitter so both ends agree on bit order.
- One natural sub-module: sipo_shift_core (shift register + bit counter + completion strobe). The top adds the holding register and handshake.

Test Plan:
1. Reset then serial_valid=1, bits 1,0,1,0, out_ready=1 → out_valid=1 one cycle after 4th bit, parallel_out=4'b1010, transfer next edge, out_valid=0.
2. MSB_FIRST=0, bits 1,0,1,1 → parallel_out=4'b1101.
3. Words 1101 then 0011 back-to-back, out_ready=0 throughout → parallel_out stays 4'b1101, overrun pulses exactly 1 cycle after 8th bit, out_valid stays 1.
4. Same as 3 but out_ready=1 only on the 8th-bit edge → first word transferred, parallel_out=4'b0011, out_valid stays 1, overrun=0.
5. Bits 1,1 then sync=1, then 0,0,1,1 → parallel_out=4'b0011, bit_count reads 0 the cycle after sync.
6. rst=1 after 2 bits, and again with out_valid=1 → all outputs 0 next cycle; next 4 bits 1,1,1,1 give 4'b1111.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared parameters for both ends of the 4-bit serial link.
// The PISO transmitter and this SIPO receiver import these defaults so word
// width and bit order always agree across the link.
package serial_link_pkg;

  // Default link word width in bits.
  localparam int LINK_WIDTH = 4;

  // 1: first bit on the wire is the word MSB; 0: first bit is the LSB.
  localparam bit LINK_MSB_FIRST = 1'b1;

endpackage

// File: rtl/sipo_shift_core.sv
// Purpose: serial shift register, bit counter and word-completion strobe.
// Latency: cand_word/cand_vld are combinational on the completion edge's inputs.
// Backpressure: none; bits are always accepted and sync wins over serial_valid.
// Ports: clk, rst (sync, active-high); serial_in/serial_valid bit input;
//        sync realign; cand_word/cand_vld completed word; bit_count partial count.
module sipo_shift_core
  import serial_link_pkg::*;
#(
  parameter int WIDTH     = LINK_WIDTH,
  parameter bit MSB_FIRST = LINK_MSB_FIRST
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       serial_in,
  input  logic                       serial_valid,
  input  logic                       sync,
  output logic [WIDTH-1:0]           cand_word,
  output logic                       cand_vld,
  output logic [$clog2(WIDTH)-1:0]   bit_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done;

  always_comb begin
    // Register contents with the current bit already shifted in; on the
    // completion edge this is the full word including its last bit.
    if (MSB_FIRST) shifted = {shift_q[WIDTH-2:0], serial_in};
    else           shifted = {serial_in, shift_q[WIDTH-1:1]};

    shift_d = shift_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    if (sync) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (serial_valid) begin
      shift_d = shifted;
      done    = (cnt_q == LAST_IDX);
      // Explicit wrap so non-power-of-two widths count correctly.
      cnt_d   = done ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cand_word = shifted;
  assign cand_vld  = done;
  assign bit_count = cnt_q;

endmodule

// File: rtl/sipo_deser.sv
// Purpose: serial-in parallel-out deserializer with a one-entry output holding register.
// Latency: word valid 1 cycle after the edge sampling its last bit; back-to-back words at 1 bit/clk.
// Backpressure: a word completing while the held word is unconsumed is dropped with a 1-cycle overrun pulse.
// Ports: clk, rst (sync, active-high); serial_in/serial_valid/sync serial side;
//        parallel_out/out_valid/out_ready consumer side; overrun, bit_count status.
module sipo_deser
  import serial_link_pkg::*;
#(
  parameter int WIDTH     = LINK_WIDTH,
  parameter bit MSB_FIRST = LINK_MSB_FIRST
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       serial_in,
  input  logic                       serial_valid,
  input  logic                       sync,
  output logic [WIDTH-1:0]           parallel_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overrun,
  output logic [$clog2(WIDTH)-1:0]   bit_count
);

  logic [WIDTH-1:0] cand_word;
  logic             cand_vld;

  logic [WIDTH-1:0] parallel_out_q, parallel_out_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic             xfer;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .sync         (sync),
    .cand_word    (cand_word),
    .cand_vld     (cand_vld),
    .bit_count    (bit_count)
  );

  // Holding register: EMPTY/FULL is simply out_valid_q.
  always_comb begin
    xfer           = out_valid_q && out_ready;
    parallel_out_d = parallel_out_q;
    out_valid_d    = out_valid_q && !xfer;
    overrun_d      = 1'b0;
    if (cand_vld) begin
      // A transfer on the same edge frees the slot, so the new word reloads it.
      if (!out_valid_q || out_ready) begin
        parallel_out_d = cand_word;
        out_valid_d    = 1'b1;
      end else begin
        overrun_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parallel_out_q <= '0;
      out_valid_q    <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      parallel_out_q <= parallel_out_d;
      out_valid_q    <= out_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign parallel_out = parallel_out_q;
  assign out_valid    = out_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b0;
  logic       serial_valid = 1'b0;
  logic       sync = 1'b0;
  logic       out_ready = 1'b0;

  logic [3:0] pout_m, pout_l;
  logic       vld_m, vld_l, ovr_m, ovr_l;
  logic [1:0] bc_m, bc_l;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] q_m[$];
  logic [3:0] q_l[$];

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .sync         (sync),
    .parallel_out (pout_m),
    .out_valid    (vld_m),
    .out_ready    (out_ready),
    .overrun      (ovr_m),
    .bit_count    (bc_m)
  );

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .sync         (sync),
    .parallel_out (pout_l),
    .out_valid    (vld_l),
    .out_ready    (out_ready),
    .overrun      (ovr_l),
    .bit_count    (bc_l)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Scoreboard: a word is consumed at the posedge where valid && ready;
  // inputs are stable at the negedge, so the pop is done there.
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (vld_m) begin
        if (q_m.size() == 0) chk("sb_m_unexpected", q_m.size(), 1);
        else chk("sb_m_word", pout_m, q_m.pop_front());
      end
      if (vld_l) begin
        if (q_l.size() == 0) chk("sb_l_unexpected", q_l.size(), 1);
        else chk("sb_l_word", pout_l, q_l.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic r);
    serial_valid = 1'b1; serial_in = b; sync = 1'b0; out_ready = r;
    tick();
  endtask

  task automatic idle(input logic r);
    serial_valid = 1'b0; serial_in = 1'b0; sync = 1'b0; out_ready = r;
    tick();
  endtask

  task automatic do_sync(input logic r);
    serial_valid = 1'b1; serial_in = 1'b1; sync = 1'b1; out_ready = r;
    tick();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; serial_valid = 1'b0; sync = 1'b0; out_ready = 1'b0;
    tick();
    chk({tag, "_pout_m"}, pout_m, 4'h0);
    chk({tag, "_pout_l"}, pout_l, 4'h0);
    chk({tag, "_vld_m"}, vld_m, 1'b0);
    chk({tag, "_vld_l"}, vld_l, 1'b0);
    chk({tag, "_ovr_m"}, ovr_m, 1'b0);
    chk({tag, "_bc_m"}, bc_m, 2'd0);
    chk({tag, "_bc_l"}, bc_l, 2'd0);
    rst = 1'b0;
  endtask

  initial begin
    do_reset("rst0");

    // 1: bits 1,0,1,0 with consumer always ready.
    q_m.push_back(4'b1010); q_l.push_back(4'b0101);
    send(1, 1); send(0, 1); send(1, 1);
    chk("t1_bc3", bc_m, 2'd3);
    send(0, 1);
    chk("t1_vld", vld_m, 1'b1);
    chk("t1_pout_m", pout_m, 4'b1010);
    chk("t1_pout_l", pout_l, 4'b0101);
    chk("t1_bc_wrap", bc_m, 2'd0);
    idle(1);
    chk("t1_vld_clr", vld_m, 1'b0);

    // 2: bits 1,0,1,1 with a serial_valid gap mid-word.
    q_m.push_back(4'b1011); q_l.push_back(4'b1101);
    send(1, 1); send(0, 1); idle(1);
    chk("t2_bc_hold", bc_l, 2'd2);
    send(1, 1); send(1, 1);
    chk("t2_pout_l", pout_l, 4'b1101);
    chk("t2_vld_l", vld_l, 1'b1);
    idle(1);
    chk("t2_vld_clr", vld_l, 1'b0);

    // 3: two words back-to-back, never ready: second word overruns.
    send(1, 0); send(1, 0); send(0, 0); send(1, 0);
    chk("t3_vld1", vld_m, 1'b1);
    chk("t3_pout1", pout_m, 4'b1101);
    send(0, 0); send(0, 0); send(1, 0);
    chk("t3_no_ovr", ovr_m, 1'b0);
    send(1, 0);
    chk("t3_ovr_m", ovr_m, 1'b1);
    chk("t3_ovr_l", ovr_l, 1'b1);
    chk("t3_pout_m_hold", pout_m, 4'b1101);
    chk("t3_pout_l_hold", pout_l, 4'b1011);
    chk("t3_vld_hold", vld_m, 1'b1);
    idle(0);
    chk("t3_ovr_pulse", ovr_m, 1'b0);
    chk("t3_pout_stable", pout_m, 4'b1101);
    q_m.push_back(4'b1101); q_l.push_back(4'b1011);
    idle(1);
    chk("t3_vld_clr", vld_m, 1'b0);

    // 4: ready only on the completion edge of the second word: reload.
    send(1, 0); send(1, 0); send(0, 0); send(1, 0);
    send(0, 0); send(0, 0); send(1, 0);
    q_m.push_back(4'b1101); q_l.push_back(4'b1011);
    send(1, 1);
    chk("t4_pout_m", pout_m, 4'b0011);
    chk("t4_pout_l", pout_l, 4'b1100);
    chk("t4_vld", vld_m, 1'b1);
    chk("t4_no_ovr", ovr_m, 1'b0);
    q_m.push_back(4'b0011); q_l.push_back(4'b1100);
    idle(1);
    chk("t4_vld_clr", vld_m, 1'b0);

    // 5: partial word discarded by sync; serial_in ignored on the sync edge.
    send(1, 1); send(1, 1);
    do_sync(1);
    chk("t5_bc_m", bc_m, 2'd0);
    chk("t5_bc_l", bc_l, 2'd0);
    chk("t5_vld", vld_m, 1'b0);
    q_m.push_back(4'b0011); q_l.push_back(4'b1100);
    send(0, 1); send(0, 1); send(1, 1); send(1, 1);
    chk("t5_pout_m", pout_m, 4'b0011);
    idle(1);

    // 6: reset mid-word, then reset with a word held.
    send(1, 0); send(0, 0);
    chk("t6_bc2", bc_m, 2'd2);
    do_reset("t6_rst_partial");
    send(0, 0); send(1, 0); send(1, 0); send(0, 0);
    chk("t6_held", pout_m, 4'b0110);
    do_reset("t6_rst_held");
    q_m.push_back(4'b1111); q_l.push_back(4'b1111);
    send(1, 1); send(1, 1); send(1, 1); send(1, 1);
    chk("t6_pout_m", pout_m, 4'b1111);
    chk("t6_pout_l", pout_l, 4'b1111);
    idle(1);
    chk("t6_vld_clr", vld_m, 1'b0);
    idle(0); idle(0);

    chk("sb_m_drain", q_m.size(), 0);
    chk("sb_l_drain", q_l.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
